sprite_ram_wr_arb: RTL and testbench



---
 rtl/sprite_ram_wr_arb_if.sv | 34 +++
 rtl/sprite_ram_wr_arb.sv | 179 +++++++++++++++++
 tb/tb_sprite_ram_wr_arb.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_ram_wr_arb_if.sv
// Sprite RAM write-port bundle: host posted writes, fill control and the RAM write port.
// The master side is the requester/bench; the slave side is the arbiter.
interface sprite_ram_wr_arb_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = DATA_WIDTH / 8
);
  logic                  host_req;
  logic                  host_rdy;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_data;
  logic [BYTE_WIDTH-1:0] host_ben;
  logic                  host_err;
  logic                  fill_start;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  fill_busy;
  logic                  fill_done;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [BYTE_WIDTH-1:0] ram_ben;

  modport master (
    output host_req, host_addr, host_data, host_ben, fill_start, fill_data,
    input  host_rdy, host_err, fill_busy, fill_done,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_ben
  );

  modport slave (
    input  host_req, host_addr, host_data, host_ben, fill_start, fill_data,
    output host_rdy, host_err, fill_busy, fill_done,
    output ram_wr_en, ram_wr_addr, ram_wr_data, ram_ben
  );
endinterface

// File: rtl/sprite_ram_wr_arb.sv
// Sprite RAM write-port arbiter: 2-entry host posted-write queue vs. constant-word fill sweep.
// Fill engine present only when SPRITE_WR_ARB_FILL_EN is defined; otherwise the host always wins.
module sprite_ram_wr_arb #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = DATA_WIDTH / 8
) (
  input  logic               wr_clk_i,
  input  logic               rst_i,
  sprite_ram_wr_arb_if.slave bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BYTE_WIDTH-1:0] ben;
  } wr_t;

  // One extra bit so DEPTH == 2**ADDR_WIDTH compares correctly.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  wr_t        q_mem [2];
  logic       q_wr_ptr;
  logic       q_rd_ptr;
  logic [1:0] q_count;
  logic [1:0] q_count_nxt;
  logic       rdy_q;
  wr_t        q_head;

  logic host_push;
  logic host_in_range;
  logic enq;
  logic pop;
  logic host_cand;
  logic grant_host;
  logic grant_fill;

  logic [ADDR_WIDTH-1:0] fill_ptr;
  logic [DATA_WIDTH-1:0] fill_word;
  logic                  fill_busy;
  logic                  fill_last;

  logic                  ram_wr_en_q;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_q;
  logic [DATA_WIDTH-1:0] ram_wr_data_q;
  logic [BYTE_WIDTH-1:0] ram_ben_q;
  logic                  host_err_q;
  logic                  fill_done_q;

  assign host_push     = bus.host_req & rdy_q;
  assign host_in_range = ({1'b0, bus.host_addr} < DEPTH_EXT);
  assign enq           = host_push & host_in_range;
  assign pop           = grant_host;
  assign host_cand     = (q_count != 2'd0);
  assign q_head        = q_mem[q_rd_ptr];

  always_comb begin
    q_count_nxt = q_count;
    if (enq && !pop) begin
      q_count_nxt = q_count + 2'd1;
    end else if (!enq && pop) begin
      q_count_nxt = q_count - 2'd1;
    end
  end

  always_ff @(posedge wr_clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_wr_ptr <= 1'b0;
      q_rd_ptr <= 1'b0;
      q_count  <= 2'd0;
      rdy_q    <= 1'b0;
    end else begin
      if (enq) q_wr_ptr <= ~q_wr_ptr;
      if (pop) q_rd_ptr <= ~q_rd_ptr;
      q_count <= q_count_nxt;
      rdy_q   <= ~q_count_nxt[1];
    end
  end

  always_ff @(posedge wr_clk_i) begin
    if (enq) begin
      q_mem[q_wr_ptr] <= '{addr: bus.host_addr, data: bus.host_data, ben: bus.host_ben};
    end
  end

`ifdef SPRITE_WR_ARB_FILL_EN
  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t state;
  state_t state_nxt;
  logic   last_fill;

  assign fill_busy = (state == S_FILL);
  assign fill_last = (fill_ptr == LAST_ADDR);

  // Round-robin on contention; the flag resets to "host" so fill wins first.
  assign grant_fill = fill_busy & (~host_cand | ~last_fill);
  assign grant_host = host_cand & ~grant_fill;

  always_ff @(posedge wr_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.fill_start) state_nxt = S_FILL;
      S_FILL:  if (grant_fill && fill_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_ptr  <= '0;
      fill_word <= '0;
      last_fill <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.fill_start) begin
        fill_ptr  <= '0;
        fill_word <= bus.fill_data;
      end else if (grant_fill && !fill_last) begin
        fill_ptr <= fill_ptr + ADDR_WIDTH'(1);
      end
      if (grant_fill || grant_host) last_fill <= grant_fill;
    end
  end
`else
  logic unused_fill_inputs;

  assign unused_fill_inputs = ^{bus.fill_start, bus.fill_data};
  assign fill_busy          = 1'b0;
  assign fill_last          = 1'b0;
  assign fill_ptr           = '0;
  assign fill_word          = '0;
  assign grant_fill         = 1'b0;
  assign grant_host         = host_cand;
`endif

  always_ff @(posedge wr_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      ram_ben_q     <= '0;
      host_err_q    <= 1'b0;
      fill_done_q   <= 1'b0;
    end else begin
      ram_wr_en_q <= grant_host | grant_fill;
      if (grant_fill) begin
        ram_wr_addr_q <= fill_ptr;
        ram_wr_data_q <= fill_word;
        ram_ben_q     <= '1;
      end else begin
        ram_wr_addr_q <= q_head.addr;
        ram_wr_data_q <= q_head.data;
        ram_ben_q     <= q_head.ben;
      end
      host_err_q  <= host_push & ~host_in_range;
      fill_done_q <= grant_fill & fill_last;
    end
  end

  assign bus.host_rdy    = rdy_q;
  assign bus.host_err    = host_err_q;
  assign bus.fill_busy   = fill_busy;
  assign bus.fill_done   = fill_done_q;
  assign bus.ram_wr_en   = ram_wr_en_q;
  assign bus.ram_wr_addr = ram_wr_addr_q;
  assign bus.ram_wr_data = ram_wr_data_q;
  assign bus.ram_ben     = ram_ben_q;

endmodule

// File: tb/tb_sprite_ram_wr_arb.sv
// Directed bench for sprite_ram_wr_arb with an in-order host scoreboard and a fill-sweep tracker.
// Fill scenarios run only when SPRITE_WR_ARB_FILL_EN is defined.
module tb_sprite_ram_wr_arb;
  localparam int DEPTH = 256;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int BW    = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] ben;
  } wr_t;

  logic wr_clk_i = 1'b0;
  logic rst_i    = 1'b1;
  always #5 wr_clk_i = ~wr_clk_i;

  sprite_ram_wr_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();

  sprite_ram_wr_arb #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) dut (
    .wr_clk_i (wr_clk_i),
    .rst_i    (rst_i),
    .bus      (bus)
  );

  int      checks   = 0;
  int      failures = 0;
  int      cyc      = 0;
  wr_t     host_q[$];
  wr_t     mon_e;
  bit      fill_exp_active = 0;
  logic [DW-1:0] fill_word = '0;
  int      fill_next      = 0;
  int      done_count     = 0;
  bit      contention     = 0;
  bit      prev_fill      = 0;
  int      host_between   = 0;
  int      first_fill_cyc = 0;
  int      done_cyc       = 0;
  bit      rdy_low_seen   = 0;

  always @(posedge wr_clk_i) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: fill writes are recognised by (next fill address, fill word); all else must be the next host write.
  always @(negedge wr_clk_i) begin
    if (contention && bus.fill_busy && !bus.host_rdy) rdy_low_seen = 1;
    if (bus.fill_done === 1'b1) done_count++;
    if (bus.ram_wr_en === 1'b1) begin
      if (fill_exp_active && bus.ram_wr_addr == AW'(fill_next) && bus.ram_wr_data == fill_word) begin
        chk("fill_ben", bus.ram_ben, 4'hF);
        chk("fill_done_flag", bus.fill_done, fill_next == DEPTH - 1);
        if (contention) chk("fill_back_to_back", prev_fill, 1'b0);
        if (fill_next == 0) first_fill_cyc = cyc;
        if (fill_next == DEPTH - 1) begin
          done_cyc        = cyc;
          fill_exp_active = 0;
        end
        fill_next++;
        prev_fill = 1;
      end else if (host_q.size() != 0) begin
        mon_e = host_q.pop_front();
        chk("host_addr", bus.ram_wr_addr, mon_e.addr);
        chk("host_data", bus.ram_wr_data, mon_e.data);
        chk("host_ben", bus.ram_ben, mon_e.ben);
        chk("host_no_done", bus.fill_done, 1'b0);
        if (fill_exp_active && fill_next > 0) host_between++;
        prev_fill = 0;
      end else begin
        chk("unexpected_write_en", bus.ram_wr_en, 1'b0);
      end
    end
  end

  // Leaves host_req high on return so consecutive calls stream one write per cycle.
  task automatic host_put(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
    int  n;
    wr_t e;
    n = 0;
    @(negedge wr_clk_i);
    bus.fill_start = 1'b0;
    while (bus.host_rdy !== 1'b1 && n < 50) begin
      bus.host_req = 1'b0;
      @(negedge wr_clk_i);
      n++;
    end
    if (bus.host_rdy !== 1'b1) begin
      chk("host_rdy_timeout", bus.host_rdy, 1'b1);
    end else begin
      bus.host_req  = 1'b1;
      bus.host_addr = a;
      bus.host_data = d;
      bus.host_ben  = b;
      if (int'(a) < DEPTH) begin
        e.addr = a;
        e.data = d;
        e.ben  = b;
        host_q.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((host_q.size() != 0 || bus.ram_wr_en === 1'b1) && n < 100) begin
      @(negedge wr_clk_i);
      #1;
      n++;
    end
    chk(tag, host_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int start_cyc;
    int n;
    int dc;

    bus.host_req   = 1'b0;
    bus.host_addr  = '0;
    bus.host_data  = '0;
    bus.host_ben   = '0;
    bus.fill_start = 1'b0;
    bus.fill_data  = '0;

    repeat (3) @(negedge wr_clk_i);
    chk("rst_host_rdy", bus.host_rdy, 1'b0);
    chk("rst_wr_en", bus.ram_wr_en, 1'b0);
    chk("rst_err", bus.host_err, 1'b0);
    chk("rst_busy", bus.fill_busy, 1'b0);
    chk("rst_done", bus.fill_done, 1'b0);
    chk("rst_addr", bus.ram_wr_addr, 0);
    rst_i = 1'b0;
    @(negedge wr_clk_i);
    chk("rdy_after_release", bus.host_rdy, 1'b1);

    // Single write: nothing on the RAM right after the accepting edge, the write one edge later.
    host_put(9'h010, 32'hDEADBEEF, 4'hF);
    @(negedge wr_clk_i);
    bus.host_req = 1'b0;
    chk("host_lat_not_early", bus.ram_wr_en, 1'b0);
    @(negedge wr_clk_i);
    chk("host_lat_en", bus.ram_wr_en, 1'b1);
    chk("host_lat_addr", bus.ram_wr_addr, 9'h010);
    chk("host_lat_data", bus.ram_wr_data, 32'hDEADBEEF);
    wait_drain("drain_single");

    host_put(9'h021, 32'h11111111, 4'hF);
    host_put(9'h022, 32'h22222222, 4'h3);
    host_put(9'h023, 32'h33333333, 4'hC);
    @(negedge wr_clk_i);
    bus.host_req = 1'b0;
    wait_drain("drain_b2b");

    // Out-of-range address is accepted but dropped with an error pulse.
    host_put(9'h100, 32'h12345678, 4'hF);
    @(negedge wr_clk_i);
    bus.host_req = 1'b0;
    chk("oor_err_pulse", bus.host_err, 1'b1);
    chk("oor_no_write_a", bus.ram_wr_en, 1'b0);
    @(negedge wr_clk_i);
    chk("oor_err_clear", bus.host_err, 1'b0);
    chk("oor_no_write_b", bus.ram_wr_en, 1'b0);
    host_put(9'h0FF, 32'hCAFEF00D, 4'h5);
    @(negedge wr_clk_i);
    bus.host_req = 1'b0;
    chk("last_addr_no_err", bus.host_err, 1'b0);
    wait_drain("drain_last_addr");

`ifdef SPRITE_WR_ARB_FILL_EN
    // Uncontended sweep of fill word 0.
    @(negedge wr_clk_i);
    fill_word       = 32'h0;
    fill_next       = 0;
    fill_exp_active = 1;
    bus.fill_data   = 32'h0;
    bus.fill_start  = 1'b1;
    start_cyc       = cyc;
    @(negedge wr_clk_i);
    bus.fill_start = 1'b0;
    chk("fill_busy_rise", bus.fill_busy, 1'b1);
    chk("fill_not_early", bus.ram_wr_en, 1'b0);
    busy_cnt = 1;
    while (bus.fill_busy === 1'b1 && busy_cnt < 600) begin
      @(negedge wr_clk_i);
      if (bus.fill_busy === 1'b1) busy_cnt++;
    end
    #1;
    chk("fill_busy_cycles", busy_cnt, DEPTH);
    chk("fill_first_lat", first_fill_cyc - start_cyc, 2);
    chk("fill_complete_a", fill_exp_active, 1'b0);
    chk("fill_done_count_a", done_count, 1);

    // Fill against a continuously offered host stream to 0x80.
    contention   = 1;
    prev_fill    = 0;
    host_between = 0;
    for (int i = 0; i < 6; i++) host_put(9'h080, 32'hA5000000 + i, 4'hF);
    fill_word       = 32'h0F0F0F0F;
    fill_next       = 0;
    fill_exp_active = 1;
    bus.fill_data   = 32'h0F0F0F0F;
    bus.fill_start  = 1'b1;
    n = 0;
    while (fill_exp_active && n < 1500) begin
      host_put(9'h080, 32'hA5000100 + n, 4'hF);
      n++;
    end
    @(negedge wr_clk_i);
    bus.host_req = 1'b0;
    wait_drain("drain_contention");
    chk("fill_complete_b", fill_exp_active, 1'b0);
    chk("host_between_fill", host_between, DEPTH - 1);
    chk("fill_within_2x", (done_cyc - first_fill_cyc) < 2 * DEPTH, 1'b1);
    chk("rdy_dropped_when_full", rdy_low_seen, 1'b1);
    chk("fill_done_count_b", done_count, 2);
    contention = 0;

    // Reset in the middle of a sweep.
    @(negedge wr_clk_i);
    fill_word       = 32'h11223344;
    fill_next       = 0;
    fill_exp_active = 1;
    bus.fill_data   = 32'h11223344;
    bus.fill_start  = 1'b1;
    @(negedge wr_clk_i);
    bus.fill_start = 1'b0;
    n = 0;
    while (fill_next < 100 && n < 300) begin
      @(negedge wr_clk_i);
      #1;
      n++;
    end
    chk("fill_reached_100", fill_next, 100);
    chk("pre_reset_wr_en", bus.ram_wr_en, 1'b1);
    dc              = done_count;
    rst_i           = 1'b1;
    fill_exp_active = 0;
    host_q.delete();
    #1;
    chk("rst_async_wr_en", bus.ram_wr_en, 1'b0);
    chk("rst_async_busy", bus.fill_busy, 1'b0);
    chk("rst_async_rdy", bus.host_rdy, 1'b0);
    repeat (3) @(negedge wr_clk_i);
    rst_i = 1'b0;
    repeat (5) @(negedge wr_clk_i);
    chk("post_rst_idle", bus.fill_busy, 1'b0);
    chk("post_rst_no_done", done_count, dc);
    chk("post_rst_rdy", bus.host_rdy, 1'b1);
    host_put(9'h044, 32'h44444444, 4'hF);
    @(negedge wr_clk_i);
    bus.host_req = 1'b0;
    @(negedge wr_clk_i);
    chk("post_rst_host_lat", bus.ram_wr_en, 1'b1);
    wait_drain("drain_post_rst");
`else
    // Without the fill engine a start pulse does nothing and host latency is unchanged.
    @(negedge wr_clk_i);
    bus.fill_data  = 32'hFFFFFFFF;
    bus.fill_start = 1'b1;
    host_put(9'h055, 32'h55555555, 4'hF);
    @(negedge wr_clk_i);
    bus.host_req = 1'b0;
    chk("nofill_busy", bus.fill_busy, 1'b0);
    @(negedge wr_clk_i);
    chk("nofill_host_lat", bus.ram_wr_en, 1'b1);
    chk("nofill_host_addr", bus.ram_wr_addr, 9'h055);
    repeat (5) @(negedge wr_clk_i);
    chk("nofill_busy_later", bus.fill_busy, 1'b0);
    chk("nofill_done_count", done_count, 0);
    wait_drain("drain_nofill");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
